// File: rtl/counter_mod_n_if.sv
// Bus bundle for counter_mod_n: control/data inputs and count/status outputs.
// The testbench (or the parent block) drives through the master modport.
interface counter_mod_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] q;
  logic             rc;
  logic             match;
  logic             wrap;

  modport master (
    output en, up, load, d, cmp,
    input  q, rc, match, wrap
  );

  modport slave (
    input  en, up, load, d, cmp,
    output q, rc, match, wrap
  );
endinterface

// File: rtl/counter_mod_n.sv
// counter_mod_n: loadable up/down modulo-MODULUS counter with combinational
// ripple carry (rc) for cascading, registered compare match and wrap pulse.
// Optional macro COUNTER_MOD_N_SATURATE_EN: terminal transitions hold at the
// end of the range instead of wrapping; wrap then never asserts.
module counter_mod_n #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  counter_mod_n_if.slave   bus
);

  // Top of the count range, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH can be compared against d without overflow.
  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             match_r;
  logic             wrap_r;
  logic             wrap_next;
  logic             at_top;
  logic             at_bottom;
  logic             d_in_range;

  assign at_top     = (q_r == Q_MAX);
  assign at_bottom  = (q_r == '0);
  assign d_in_range = ({1'b0, bus.d} < MOD_EXT);

  // Ripple carry is deliberately independent of load so a cascade sees the
  // same terminal-count indication whether or not this stage is being loaded.
  assign bus.rc    = bus.en & ((bus.up & at_top) | (~bus.up & at_bottom));
  assign bus.q     = q_r;
  assign bus.match = match_r;
  assign bus.wrap  = wrap_r;

  // Next-count and wrap decision: load beats enable, enable beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    q_next    = q_r;
    wrap_next = 1'b0;
    if (bus.load) begin
      q_next = d_in_range ? bus.d : Q_MAX;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_top) begin
`ifdef COUNTER_MOD_N_SATURATE_EN
          q_next    = Q_MAX;
`else
          q_next    = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_r + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
`ifdef COUNTER_MOD_N_SATURATE_EN
          q_next    = '0;
`else
          q_next    = Q_MAX;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = q_r - WIDTH'(1);
        end
      end
    end
  end

  // State register with synchronous reset; match tracks the value q takes
  // on this edge so it lines up with the visible count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      q_r     <= '0;
      match_r <= (bus.cmp == '0);
      wrap_r  <= 1'b0;
    end else begin
      q_r     <= q_next;
      match_r <= (q_next == bus.cmp);
      wrap_r  <= wrap_next;
    end
  end

endmodule

// File: doc/counter_mod_n.md
COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 16, giving the count range 0..MODULUS-1 (legal range 2..2^WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port d, input, WIDTH bits: the parallel load value.
REQ-009 The block SHALL have port cmp, input, WIDTH bits: the match target.
REQ-010 The block SHALL have port q, output, WIDTH bits: the registered count.
REQ-011 The block SHALL have port rc, output, 1 bit: combinational terminal-count/ripple carry.
REQ-012 The block SHALL have port match, output, 1 bit: registered, asserted while q == cmp (one cycle latency).
REQ-013 The block SHALL have port wrap, output, 1 bit: registered single-cycle pulse, asserted for the cycle after q wrapped.

Function
REQ-014 Each rising edge SHALL apply this priority: rst, then load, then en, then hold.
REQ-015 When load=1, q SHALL take d if d < MODULUS, otherwise MODULUS-1. load SHALL take effect regardless of en.
REQ-016 When en=1, up=1 and q < MODULUS-1, q SHALL take q+1.
REQ-017 When en=1, up=1 and q = MODULUS-1, q SHALL take 0 and wrap SHALL be 1 on the next cycle.
REQ-018 When en=1, up=0 and q > 0, q SHALL take q-1.
REQ-019 When en=1, up=0 and q = 0, q SHALL take MODULUS-1 and wrap SHALL be 1 on the next cycle.
REQ-020 When en=0 and load=0, q SHALL hold, and wrap SHALL be 0 on the next cycle.
REQ-021 rc SHALL equal en & ((up & q==MODULUS-1) | (~up & q==0)), purely combinational, for cascading into the en of the next stage.
REQ-022 match SHALL be registered from (next q == cmp); it therefore reflects the q value visible in the same cycle.
REQ-023 A load coinciding with a terminal count SHALL NOT assert wrap.
REQ-024 Arithmetic SHALL be performed modulo MODULUS only, with no intermediate overflow beyond WIDTH bits.
REQ-025 A direction change on any cycle SHALL take effect on that same edge, with no extra latency.

Reset
REQ-026 When rst=1 at a rising edge, q SHALL become 0, match SHALL become (cmp==0), and wrap SHALL become 0; rst overrides load and en.
REQ-027 A reset asserted mid-count SHALL discard any pending wrap pulse.
REQ-028 After rst deasserts, counting SHALL resume on the first edge with en=1.

Configuration
REQ-029 When the macro COUNTER_MOD_N_SATURATE_EN is defined, the terminal transitions in REQ-017 and REQ-019 SHALL hold q at MODULUS-1 (up) or 0 (down) instead of wrapping; wrap SHALL stay 0; rc behaviour SHALL be unchanged.
REQ-030 When COUNTER_MOD_N_SATURATE_EN is undefined, the wrap-around behaviour SHALL apply and no saturation logic SHALL be present.

Verification
REQ-031 Reset, then WIDTH=4, MODULUS=10, en=1, up=1 for 12 cycles -> q = 0..9,0,1; rc=1 only at q=9; wrap=1 only in the cycle q=0 after 9.
REQ-032 From q=0, up=0, en=1 with MODULUS=10 -> q=9; rc=1 in the q=0 cycle; wrap=1 the next cycle.
REQ-033 Assert load=1 with d=7, en=1, up=1 at q=9 -> q=7, wrap=0; assert load with d=12 -> q=9.
REQ-034 With cmp=5, count up from 0 -> match=1 exactly while q=5; assert rst with en=1 at q=6 -> q=0, wrap=0.
REQ-035 Cascade two instances (WIDTH=4, MODULUS=10) with stage-0 rc driving stage-1 en, and count for 100 cycles -> {q1,q0} steps BCD 00..99 then returns to 00.
REQ-036 With COUNTER_MOD_N_SATURATE_EN defined, MODULUS=16, and up held for 20 cycles from 0 -> q sticks at 15, wrap stays 0, rc stays 1 while en=1.
